// File: rtl/fetch_prefetch.sv
// Instruction-fetch stage: owns the PC, issues word requests to instruction memory and
// buffers in-order responses in a DEPTH-entry prefetch queue feeding decode with {inst, pc}.
module fetch_prefetch #(
  parameter int              XLEN     = 32,
  parameter int              ILEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [ILEN-1:0] imem_resp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [ILEN-1:0] inst_data,
  output logic [XLEN-1:0] inst_pc
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  // Handshakes: a transfer happens on a cycle where both valid and ready are high at posedge;
  // imem_req_valid may be withdrawn without acceptance only in a redirect or reset cycle.

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] resp_pc_q;
  logic [ILEN-1:0] q_data [DEPTH];
  logic [XLEN-1:0] q_pc   [DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [CW-1:0]   count;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   drop;

  logic [CW:0]     in_use;
  logic            acc;
  logic            resp;
  logic            discard;
  logic            push;
  logic            pop;
  logic [CW-1:0]   outstanding_next;
  logic [CW-1:0]   count_next;
  logic [CW-1:0]   drop_next;
  logic [XLEN-1:0] redirect_aligned;
  logic            redirect_lsb_unused;

  assign redirect_aligned    = {redirect_pc[XLEN-1:2], 2'b00};
  assign redirect_lsb_unused = ^redirect_pc[1:0];

  // Credit check: every issued request already owns a queue slot, so the queue cannot overflow.
  assign in_use         = {1'b0, outstanding} + {1'b0, count};
  assign imem_req_valid = !rst && !redirect_valid && (in_use < (CW + 1)'(DEPTH));
  assign imem_req_addr  = pc_q;

  assign acc     = imem_req_valid && imem_req_ready;
  assign resp    = imem_resp_valid && (outstanding != '0);
  assign discard = resp && (drop != '0);
  assign push    = resp && (drop == '0) && !redirect_valid;
  assign pop     = inst_valid && inst_ready && !redirect_valid;

  assign inst_valid = (count != '0);
  assign inst_data  = q_data[rd_ptr];
  assign inst_pc    = q_pc[rd_ptr];

  always_comb begin
    outstanding_next = outstanding + {{(CW-1){1'b0}}, acc} - {{(CW-1){1'b0}}, resp};

    count_next = count;
    if (redirect_valid) begin
      count_next = '0;
    end else if (push && !pop) begin
      count_next = count + 1'b1;
    end else if (pop && !push) begin
      count_next = count - 1'b1;
    end

    // A redirect turns every request still in flight into a word that must be thrown away.
    drop_next = drop - {{(CW-1){1'b0}}, discard};
    if (redirect_valid) begin
      drop_next = outstanding_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q        <= RESET_PC;
      resp_pc_q   <= RESET_PC;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      outstanding <= '0;
      drop        <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q_data[i] <= '0;
        q_pc[i]   <= RESET_PC;
      end
    end else begin
      outstanding <= outstanding_next;
      count       <= count_next;
      drop        <= drop_next;

      if (redirect_valid) begin
        pc_q      <= redirect_aligned;
        resp_pc_q <= redirect_aligned;
        rd_ptr    <= '0;
        wr_ptr    <= '0;
      end else begin
        if (acc) begin
          pc_q <= pc_q + XLEN'(4);
        end
        if (push) begin
          q_data[wr_ptr] <= imem_resp_data;
          q_pc[wr_ptr]   <= resp_pc_q;
          wr_ptr         <= wr_ptr + 1'b1;
          resp_pc_q      <= resp_pc_q + XLEN'(4);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + 1'b1;
        end
      end
    end
  end

  // Memory must never answer a request that was not issued.
  resp_has_request: assert property (@(posedge clk) disable iff (rst)
    imem_resp_valid |-> (outstanding != '0));

endmodule

// File: tb/tb_fetch_prefetch.sv
// Directed bench for fetch_prefetch: a responder model returns data = addr + 0x1000_0000
// one cycle after each accepted request; checks are immediate assertions.
module tb_fetch_prefetch;

  localparam int XLEN = 32;
  localparam int ILEN = 32;
  localparam logic [XLEN-1:0] DOFS = 32'h1000_0000;

  logic            clk = 1'b0;
  logic            rst;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_resp_valid = 1'b0;
  logic [ILEN-1:0] imem_resp_data = '0;
  logic            inst_valid;
  logic            inst_ready;
  logic [ILEN-1:0] inst_data;
  logic [XLEN-1:0] inst_pc;

  int tests  = 0;
  int failed = 0;

  logic [XLEN-1:0] pend_q[$];
  logic            resp_en = 1'b1;
  int              acc_cnt = 0;
  logic            acc_l   = 1'b0;
  logic            resp_l  = 1'b0;
  logic            rst_l   = 1'b1;
  logic [XLEN-1:0] addr_l  = '0;

  fetch_prefetch #(.XLEN(XLEN), .ILEN(ILEN), .DEPTH(4), .RESET_PC('0)) dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_data(inst_data), .inst_pc(inst_pc)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, observed timeout required finish");
    $fatal(1, "watchdog expired");
  end

  // Memory responder: sample the handshake mid-cycle, update just after the edge.
  always @(negedge clk) begin
    acc_l  = imem_req_valid && imem_req_ready;
    addr_l = imem_req_addr;
    resp_l = imem_resp_valid;
    rst_l  = rst;
    if (acc_l) acc_cnt++;
  end

  always @(posedge clk) begin
    #1;
    if (rst_l) begin
      pend_q.delete();
    end else begin
      if (resp_l && pend_q.size() > 0) void'(pend_q.pop_front());
      if (acc_l) pend_q.push_back(addr_l);
    end
    if (!rst_l && resp_en && pend_q.size() > 0) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = pend_q[0] + DOFS;
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = '0;
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_inst(input string tag);
    int n = 0;
    while (!inst_valid && n < 12) begin
      tick();
      n++;
    end
    check(tag, inst_valid, 1);
  endtask

  initial begin
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    imem_req_ready = 1'b1; inst_ready = 1'b1;
    repeat (3) tick();

    // Reset state
    check("rst_req_valid", imem_req_valid, 0);
    check("rst_inst_valid", inst_valid, 0);
    check("rst_req_addr", imem_req_addr, 32'h0);
    check("rst_inst_data", inst_data, 32'h0);
    check("rst_inst_pc", inst_pc, 32'h0);

    // Sequential fetch with a 1-cycle memory
    rst = 1'b0; #1;
    check("seq_c0_valid", imem_req_valid, 1);
    check("seq_c0_addr", imem_req_addr, 32'h0);
    tick();
    check("seq_c1_addr", imem_req_addr, 32'h4);
    check("seq_c1_inst_valid", inst_valid, 0);
    tick();
    check("seq_c2_inst_valid", inst_valid, 1);
    check("seq_c2_inst_pc", inst_pc, 32'h0);
    check("seq_c2_inst_data", inst_data, 32'h1000_0000);
    check("seq_c2_addr", imem_req_addr, 32'h8);
    tick();
    check("seq_c3_inst_pc", inst_pc, 32'h4);
    check("seq_c3_inst_data", inst_data, 32'h1000_0004);
    tick();
    check("seq_c4_inst_pc", inst_pc, 32'h8);

    // Back-pressure from decode fills the queue
    rst = 1'b1; inst_ready = 1'b0;
    tick(); tick();
    rst = 1'b0; acc_cnt = 0;
    repeat (10) tick();
    check("full_acc_cnt", acc_cnt, 4);
    check("full_req_valid", imem_req_valid, 0);
    check("full_inst_valid", inst_valid, 1);
    check("full_inst_pc", inst_pc, 32'h0);
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0; #1;
    check("pop_req_valid", imem_req_valid, 1);
    check("pop_req_addr", imem_req_addr, 32'h10);
    check("pop_inst_pc", inst_pc, 32'h4);
    tick();
    check("refull_req_valid", imem_req_valid, 0);
    check("refull_acc_cnt", acc_cnt, 5);

    // Memory not ready: request held with a stable address
    imem_req_ready = 1'b0; inst_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_req_valid", imem_req_valid, 1);
      check("stall_req_addr", imem_req_addr, 32'h14);
    end
    imem_req_ready = 1'b1;
    tick();
    check("stall_release_addr", imem_req_addr, 32'h18);

    // Redirect in a cycle carrying a response
    tick();
    check("r5_resp_present", imem_resp_valid, 1);
    redirect_valid = 1'b1; redirect_pc = 32'h202; #1;
    check("r5_req_withdrawn", imem_req_valid, 0);
    tick();
    redirect_valid = 1'b0; #1;
    check("r5_addr", imem_req_addr, 32'h200);
    check("r5_req_valid", imem_req_valid, 1);
    check("r5_flushed", inst_valid, 0);
    tick();
    check("r5_no_stale", inst_valid, 0);
    tick();
    check("r5_first_valid", inst_valid, 1);
    check("r5_first_pc", inst_pc, 32'h200);
    check("r5_first_data", inst_data, 32'h1000_0200);

    // Back-to-back redirects: last one wins
    redirect_valid = 1'b1; redirect_pc = 32'h300;
    tick();
    redirect_pc = 32'h400;
    tick();
    redirect_valid = 1'b0; #1;
    check("b2b_addr", imem_req_addr, 32'h400);
    wait_inst("b2b_wait");
    check("b2b_first_pc", inst_pc, 32'h400);

    // Redirect with two responses in flight
    rst = 1'b1; resp_en = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick(); tick();
    check("drop_req_addr_before", imem_req_addr, 32'h8);
    redirect_valid = 1'b1; redirect_pc = 32'h103; #1;
    check("drop_req_withdrawn", imem_req_valid, 0);
    tick();
    redirect_valid = 1'b0; resp_en = 1'b1; #1;
    check("drop_addr", imem_req_addr, 32'h100);
    check("drop_req_valid", imem_req_valid, 1);
    check("drop_empty", inst_valid, 0);
    wait_inst("drop_wait");
    check("drop_first_pc", inst_pc, 32'h100);
    check("drop_first_data", inst_data, 32'h1000_0100);
    tick();
    check("drop_second_pc", inst_pc, 32'h104);

    // PC wrap at the top of the address space
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFE;
    tick();
    redirect_valid = 1'b0; #1;
    check("wrap_addr_top", imem_req_addr, 32'hFFFF_FFFC);
    tick();
    check("wrap_addr_zero", imem_req_addr, 32'h0);
    wait_inst("wrap_wait");
    check("wrap_pc_top", inst_pc, 32'hFFFF_FFFC);
    check("wrap_data_top", inst_data, 32'h0FFF_FFFC);
    tick();
    check("wrap_pc_zero", inst_pc, 32'h0);

    // Reset in the middle of traffic
    rst = 1'b1;
    tick();
    check("midrst_inst_valid", inst_valid, 0);
    check("midrst_req_addr", imem_req_addr, 32'h0);
    check("midrst_inst_pc", inst_pc, 32'h0);
    check("midrst_inst_data", inst_data, 32'h0);
    rst = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
